// File: rtl/clock_pkg.sv
// Shared types and constants for the lab digital clock controller.
// The state encoding doubles as the external sel output.
package clock_pkg;

    typedef enum logic [1:0] {
        StRun  = 2'd0,
        StSetH = 2'd1,
        StSetM = 2'd2,
        StSetS = 2'd3
    } state_e;

    localparam int unsigned HOUR_W = 5;
    localparam int unsigned MIN_W  = 6;
    localparam int unsigned SEC_W  = 6;

    localparam logic [SEC_W-1:0] SEC_MAX = SEC_W'(59);
    localparam logic [MIN_W-1:0] MIN_MAX = MIN_W'(59);

    // Increment a minute/second field, wrapping at its maximum.
    function automatic logic [5:0] inc_wrap6(input logic [5:0] v, input logic [5:0] max);
        return (v == max) ? 6'd0 : v + 6'd1;
    endfunction

    // Field selection order in set mode: hours -> minutes -> seconds -> hours.
    function automatic state_e next_field(input state_e s);
        state_e n;
        unique case (s)
            StSetH:  n = StSetM;
            StSetM:  n = StSetS;
            StSetS:  n = StSetH;
            StRun:   n = StRun;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/rise_edge.sv
// Rising-edge detector for a debounced synchronous button.
// Pulse is high for the single cycle where the input is 1 and its last sample was 0.
module rise_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic pulse
);

    logic last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b0;
        end else begin
            last_q <= d;
        end
    end

    assign pulse = d & ~last_q;

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-of-day keeper with 1 Hz prescaler and a button-driven set-time mode.
// Fields always stay in range; the only ways to change them are the tick ripple and the set buttons.
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned DIV      = 50_000_000,
    parameter int unsigned HOUR_MAX = 23
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode,
    input  logic              btn_sel,
    input  logic              btn_inc,
    output logic [HOUR_W-1:0] hour,
    output logic [MIN_W-1:0]  min,
    output logic [SEC_W-1:0]  sec,
    output logic [1:0]        sel,
    output logic              blink,
    output logic              sec_pulse
);

    localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]     PRESC_LAST = PW'(DIV - 1);
    localparam logic [PW-1:0]     PRESC_HALF = PW'(DIV / 2);
    localparam logic [HOUR_W-1:0] HOUR_LAST  = HOUR_W'(HOUR_MAX);

    state_e            state_q, state_d;
    logic [PW-1:0]     presc_q, presc_d;
    logic [HOUR_W-1:0] hour_q, hour_d;
    logic [MIN_W-1:0]  min_q, min_d;
    logic [SEC_W-1:0]  sec_q, sec_d;
    logic              pulse_q, pulse_d;
    logic              blink_q, blink_d;
    logic              sel_edge, inc_edge;
    logic              tick;

    rise_edge u_sel_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (btn_sel),
        .pulse (sel_edge)
    );

    rise_edge u_inc_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (btn_inc),
        .pulse (inc_edge)
    );

    assign tick = (presc_q == PRESC_LAST);

    always_comb begin
        state_d = state_q;
        presc_d = tick ? '0 : presc_q + PW'(1);
        hour_d  = hour_q;
        min_d   = min_q;
        sec_d   = sec_q;
        pulse_d = 1'b0;
        blink_d = (state_q != StRun) && (presc_q < PRESC_HALF);

        unique case (state_q)
            StRun: begin
                // Entering set mode wins over a coincident tick.
                if (mode) begin
                    state_d = StSetH;
                    presc_d = '0;
                end else if (tick) begin
                    pulse_d = 1'b1;
                    sec_d   = inc_wrap6(sec_q, SEC_MAX);
                    if (sec_q == SEC_MAX) begin
                        min_d = inc_wrap6(min_q, MIN_MAX);
                        if (min_q == MIN_MAX) begin
                            hour_d = (hour_q == HOUR_LAST) ? '0 : hour_q + HOUR_W'(1);
                        end
                    end
                end
            end
            StSetH, StSetM, StSetS: begin
                if (!mode) begin
                    state_d = StRun;
                    presc_d = '0;
                end else begin
                    if (inc_edge) begin
                        unique case (state_q)
                            StSetH:  hour_d = (hour_q == HOUR_LAST) ? '0 : hour_q + HOUR_W'(1);
                            StSetM:  min_d  = inc_wrap6(min_q, MIN_MAX);
                            StSetS:  sec_d  = inc_wrap6(sec_q, SEC_MAX);
                            StRun:   ;
                        endcase
                    end
                    if (sel_edge) begin
                        state_d = next_field(state_q);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StRun;
            presc_q <= '0;
            hour_q  <= '0;
            min_q   <= '0;
            sec_q   <= '0;
            pulse_q <= 1'b0;
            blink_q <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            hour_q  <= hour_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            pulse_q <= pulse_d;
            blink_q <= blink_d;
        end
    end

    assign hour      = hour_q;
    assign min       = min_q;
    assign sec       = sec_q;
    assign sel       = state_q;
    assign blink     = blink_q;
    assign sec_pulse = pulse_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with DIV=4: counting, set sequencing, wrap, edges, reset.
module tb_clock_set_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mode = 1'b0;
    logic       btn_sel = 1'b0;
    logic       btn_inc = 1'b0;
    logic [4:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
    logic [1:0] sel;
    logic       blink;
    logic       sec_pulse;

    int checks = 0;
    int failures = 0;
    int pulses = 0;

    clock_set_ctrl #(
        .DIV      (4),
        .HOUR_MAX (23)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .btn_sel   (btn_sel),
        .btn_inc   (btn_inc),
        .hour      (hour),
        .min       (min),
        .sec       (sec),
        .sel       (sel),
        .blink     (blink),
        .sec_pulse (sec_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance n clock edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_inc();
        btn_inc = 1'b1;
        step(1);
        btn_inc = 1'b0;
        step(1);
    endtask

    task automatic pulse_sel();
        btn_sel = 1'b1;
        step(1);
        btn_sel = 1'b0;
        step(1);
    endtask

    task automatic check_time(input string tag, input int h, input int m, input int s);
        check({tag, "_hour"}, int'(hour), h);
        check({tag, "_min"}, int'(min), m);
        check({tag, "_sec"}, int'(sec), s);
    endtask

    initial begin
        // Reset state before any clock edge
        #2;
        check_time("reset", 0, 0, 0);
        check("reset_sel", int'(sel), 0);
        check("reset_blink", int'(blink), 0);
        check("reset_pulse", int'(sec_pulse), 0);
        step(2);
        rst_n = 1'b1;

        // Run count: pulse on every 4th edge, 60 seconds -> 00:01:00
        for (int i = 1; i <= 240; i++) begin
            step(1);
            check("run_pulse_phase", int'(sec_pulse), (i % 4 == 0) ? 1 : 0);
            if (sec_pulse) pulses++;
        end
        check("run_pulse_count", pulses, 60);
        check_time("run_end", 0, 1, 0);
        check("run_blink", int'(blink), 0);
        check("run_sel", int'(sel), 0);

        // btn_inc in RUN is ignored (prescaler 0 -> 2 here)
        btn_inc = 1'b1;
        step(1);
        check_time("run_inc_a", 0, 1, 0);
        btn_inc = 1'b0;
        step(1);
        check_time("run_inc_b", 0, 1, 0);

        // Prescaler now 3 after this edge: mode rises during the tick cycle
        step(1);
        mode = 1'b1;
        step(1);
        check("tick_mode_sel", int'(sel), 1);
        check("tick_mode_pulse", int'(sec_pulse), 0);
        check_time("tick_mode", 0, 1, 0);
        check("blink_0", int'(blink), 0);

        // Blink follows prescaler: high for prescaler 0,1 then low for 2,3
        step(1);
        check("blink_1", int'(blink), 1);
        step(1);
        check("blink_2", int'(blink), 1);
        step(1);
        check("blink_3", int'(blink), 0);
        step(1);
        check("blink_4", int'(blink), 0);
        step(1);
        check("blink_5", int'(blink), 1);

        // Set sequencing
        repeat (3) pulse_inc();
        check("set_hour3", int'(hour), 3);
        pulse_sel();
        check("set_sel2", int'(sel), 2);
        repeat (58) pulse_inc();
        check("set_min59", int'(min), 59);
        pulse_inc();
        check("set_min_wrap", int'(min), 0);
        check("set_min_nocarry", int'(hour), 3);
        pulse_sel();
        check("set_sel3", int'(sel), 3);
        pulse_sel();
        check("set_sel1", int'(sel), 1);

        // Simultaneous sel+inc in SET_H at hour=5
        repeat (2) pulse_inc();
        check("simul_pre_hour", int'(hour), 5);
        btn_sel = 1'b1;
        btn_inc = 1'b1;
        step(1);
        btn_sel = 1'b0;
        btn_inc = 1'b0;
        check("simul_hour", int'(hour), 6);
        check("simul_sel", int'(sel), 2);
        step(1);

        // Held btn_inc in SET_S counts once
        pulse_sel();
        check("held_sel", int'(sel), 3);
        btn_inc = 1'b1;
        step(10);
        btn_inc = 1'b0;
        step(1);
        check("held_sec", int'(sec), 1);

        // Build 23:59:59 then roll over in RUN
        repeat (58) pulse_inc();
        pulse_sel();
        repeat (17) pulse_inc();
        pulse_sel();
        repeat (59) pulse_inc();
        check_time("roll_pre", 23, 59, 59);
        mode = 1'b0;
        step(1);
        check("roll_sel_run", int'(sel), 0);
        for (int i = 1; i <= 3; i++) begin
            step(1);
            check_time("roll_wait", 23, 59, 59);
            check("roll_wait_pulse", int'(sec_pulse), 0);
        end
        step(1);
        check_time("roll_done", 0, 0, 0);
        check("roll_pulse", int'(sec_pulse), 1);
        step(1);
        check("roll_pulse_end", int'(sec_pulse), 0);

        // Asynchronous reset mid-edit
        mode = 1'b1;
        step(1);
        pulse_inc();
        pulse_inc();
        check("edit_hour", int'(hour), 2);
        #2;
        rst_n = 1'b0;
        #1;
        check_time("async_rst", 0, 0, 0);
        check("async_rst_sel", int'(sel), 0);
        check("async_rst_blink", int'(blink), 0);

        // mode held high across reset release enters SET_H on first edge
        step(1);
        rst_n = 1'b1;
        step(1);
        check("mode_at_release_sel", int'(sel), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
